priority_input_debouncer: RTL and testbench
===========================================

PRIORITY_INPUT_DEBOUNCER -- requirements
Module: priority_input_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples required before an input bit change is accepted; legal range 1..65535.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 ena  input  1  count enable; high = debounce counters advance, low = counters and data frozen.
REQ-005 raw  input  8  asynchronous switch/button levels; bit 7 highest priority downstream.
REQ-006 data  output  8  debounced, registered input vector feeding the priority encoder data input.
REQ-007 changed  output  1  one-cycle strobe, high in the cycle after any data bit updates.
REQ-008 busy  output  1  high while any bit's debounce counter is non-zero.

Function
REQ-009 Each raw bit SHALL pass through a 2-flop synchronizer; the second flop (sync) is the only value compared against data.
REQ-010 Per bit, when ena=1 and sync != data, the counter SHALL increment by 1 each clock.
REQ-011 Per bit, when sync == data, the counter SHALL clear to 0 on the next clock, regardless of ena.
REQ-012 When ena=1, sync != data and counter == DEBOUNCE_CYCLES-1, the data bit SHALL take the sync value and the counter SHALL clear on that same edge.
REQ-013 Latency: raw change sampled by the first synchronizer flop at edge S and held SHALL appear on data at edge S+1+DEBOUNCE_CYCLES (ena=1 throughout).
REQ-014 A raw pulse or glitch whose synchronized value lasts fewer than DEBOUNCE_CYCLES clocks SHALL leave data unchanged.
REQ-015 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits; counter SHALL never exceed DEBOUNCE_CYCLES-1 and never wrap.
REQ-016 Bits SHALL debounce independently; several bits updating on the same edge SHALL produce exactly one changed pulse.
REQ-017 changed SHALL be registered: high for exactly one cycle following each edge on which data changed; back-to-back updates on consecutive edges yield changed high on consecutive cycles.
REQ-018 ena=0 SHALL hold counters and data; synchronizers keep sampling; counting resumes from the held value when ena returns high.
REQ-019 busy SHALL be the registered OR of all counters being non-zero.
REQ-020 data SHALL change only through REQ-012; no combinational path from raw to any output.

Reset
REQ-021 rst_n low SHALL asynchronously clear synchronizers, counters and data to 0, changed to 0, busy to 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count; after release, a still-held raw level needs the full latency of REQ-013 again.
REQ-023 Release of rst_n SHALL not itself generate a changed pulse.

Structure
REQ-024 DEBOUNCE_CYCLES default and the data width constant (8) SHALL live in the shared package prio_pkg, alongside the priority encoder's constants.
REQ-025 One sub-module, debounce_bit (synchronizer + counter + data flop for one bit), SHALL be instantiated 8 times; top level holds the changed/busy logic.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, raw 0x00->0x80 at edge S, held -> data=0x80 at S+5, changed high one cycle only, busy high S+2..S+4.
REQ-027 raw bit 3 high for 3 synchronized cycles then low -> data stays 0x00, changed never asserts, busy returns low.
REQ-028 raw 0x00->0x21 (two bits same edge) -> data=0x21 at S+5 with a single changed pulse.
REQ-029 raw 0x00->0x04, ena low for 10 cycles after 2 counts, then high -> data=0x04 exactly 2 enabled cycles after ena returns.
REQ-030 raw 0x00->0x40, rst_n pulsed low after 2 counts, released -> data=0x00 during reset, data=0x40 full latency after release, no changed on release.
REQ-031 raw toggling bit 0 every 2 clocks for 40 cycles -> data bit 0 constant 0, changed never asserts.

Source files
------------

// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared constants and types for the priority input path
package prio_pkg;

  // Width of the input vector feeding the priority encoder.
  localparam int DATA_W = 8;

  // Default number of stable synchronized samples before a bit change is accepted.
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Priority encoder index width and types.
  localparam int PRIO_IDX_W = $clog2(DATA_W);

  typedef logic [DATA_W-1:0]     prio_vec_t;
  typedef logic [PRIO_IDX_W-1:0] prio_idx_t;

  // Bits needed to hold a count of 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/priority_input_debouncer_if.sv
// rtl/priority_input_debouncer_if.sv - enable/raw inputs and debounced outputs bundle
import prio_pkg::*;

interface priority_input_debouncer_if;
  logic      ena;
  prio_vec_t raw;
  prio_vec_t data;
  logic      changed;
  logic      busy;

  // Driver side: supplies enable and raw levels, observes debounced results.
  modport master (
    output ena,
    output raw,
    input  data,
    input  changed,
    input  busy
  );

  // Debouncer side.
  modport slave (
    input  ena,
    input  raw,
    output data,
    output changed,
    output busy
  );
endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchronizer, stability counter and data flop
import prio_pkg::*;

module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic data,
  output logic update,
  output logic busy_next
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          data_next;

  // Next-state: clear on agreement, count while enabled, accept on the last count.
  always_comb begin
    cnt_next  = cnt;
    data_next = data;
    update    = 1'b0;
    if (sync == data) begin
      cnt_next = '0;
    end else if (ena) begin
      if (cnt == LAST) begin
        data_next = sync;
        cnt_next  = '0;
        update    = 1'b1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
    busy_next = (cnt_next != '0);
  end

  // Two-flop synchronizer plus counter and accepted-data state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      cnt       <= '0;
      data      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      cnt       <= cnt_next;
      data      <= data_next;
    end
  end

endmodule

// File: rtl/priority_input_debouncer.sv
// rtl/priority_input_debouncer.sv - eight independent debouncers with change strobe and busy flag
import prio_pkg::*;

module priority_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  priority_input_debouncer_if.slave   bus
);

  prio_vec_t data_bits;
  prio_vec_t upd;
  prio_vec_t busy_nx;
  logic      changed_q;
  logic      busy_q;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (bus.ena),
      .raw       (bus.raw[i]),
      .data      (data_bits[i]),
      .update    (upd[i]),
      .busy_next (busy_nx[i])
    );
  end

  // One strobe per accepting edge no matter how many bits flip; busy mirrors the counters just loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      changed_q <= |upd;
      busy_q    <= |busy_nx;
    end
  end

  assign bus.data    = data_bits;
  assign bus.changed = changed_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_priority_input_debouncer.sv
// tb/tb_priority_input_debouncer.sv - scoreboard bench for priority_input_debouncer
import prio_pkg::*;

module tb_priority_input_debouncer;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  priority_input_debouncer_if bus();

  priority_input_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive raw; if an update is expected, the strobe is seen DC+2 edges later (plus any frozen cycles).
  task automatic drive(input logic [7:0] v, input bit expect_update, input int extra);
    bus.raw = v;
    if (expect_update) sb.push_back('{v, cyc + 2 + DC + extra});
  endtask

  // Wait (bounded) for the scoreboard to empty and counters to go idle.
  task automatic drain(input string name);
    for (int i = 0; i < 60 && (sb.size() != 0 || bus.busy !== 1'b0); i++) tick(1);
    tick(2);
    check({name, "_pending"}, sb.size(), 0);
    check({name, "_busy_idle"}, bus.busy, 1'b0);
  endtask

  // Monitor: every changed strobe must match the oldest expected update in value and timing.
  always @(negedge clk) begin
    exp_t e;
    if (bus.changed === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL changed_unexpected actual data=%0h cycle=%0d required no pulse", bus.data, cyc);
      end else begin
        e = sb.pop_front();
        check("changed_data", bus.data, e.data);
        check("changed_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    bus.ena = 1'b1;
    bus.raw = 8'h00;
    tick(3);
    check("reset_data", bus.data, 8'h00);
    check("reset_changed", bus.changed, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick(3);
    check("post_reset_data", bus.data, 8'h00);

    // Single bit, exact busy window and data latency.
    drive(8'h80, 1'b1, 0);
    for (int j = 0; j < 7; j++) begin
      tick(1);
      check("c1_busy", bus.busy, (j >= 2 && j <= 4) ? 1'b1 : 1'b0);
      check("c1_data", bus.data, (j >= 5) ? 8'h80 : 8'h00);
    end
    drain("c1");
    drive(8'h00, 1'b1, 0);
    drain("c1_back");

    // Glitch of three synchronized cycles is rejected.
    drive(8'h08, 1'b0, 0);
    tick(3);
    drive(8'h00, 1'b0, 0);
    drain("c2");
    check("c2_data", bus.data, 8'h00);

    // Two bits on the same edge, one strobe.
    drive(8'h21, 1'b1, 0);
    drain("c3");
    check("c3_data", bus.data, 8'h21);
    drive(8'h00, 1'b1, 0);
    drain("c3_back");

    // Freeze after two counts for ten cycles.
    drive(8'h04, 1'b1, 10);
    tick(4);
    bus.ena = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      check("c4_frozen_busy", bus.busy, 1'b1);
      check("c4_frozen_data", bus.data, 8'h00);
    end
    bus.ena = 1'b1;
    tick(1);
    check("c4_one_enabled", bus.data, 8'h00);
    tick(1);
    check("c4_two_enabled", bus.data, 8'h04);
    drain("c4");
    drive(8'h00, 1'b1, 0);
    drain("c4_back");

    // Reset mid-count discards progress; full latency after release.
    drive(8'h40, 1'b0, 0);
    tick(4);
    rst_n = 1'b0;
    #1;
    check("c5_rst_data", bus.data, 8'h00);
    check("c5_rst_busy", bus.busy, 1'b0);
    check("c5_rst_changed", bus.changed, 1'b0);
    tick(2);
    check("c5_held_data", bus.data, 8'h00);
    rst_n = 1'b1;
    sb.push_back('{8'h40, cyc + 2 + DC});
    tick(DC + 1);
    check("c5_before_latency", bus.data, 8'h00);
    drain("c5");
    check("c5_data", bus.data, 8'h40);
    drive(8'h00, 1'b1, 0);
    drain("c5_back");

    // Bit 0 toggling every two clocks never settles.
    for (int i = 0; i < 20; i++) begin
      bus.raw = (i % 2 == 0) ? 8'h01 : 8'h00;
      tick(2);
      check("c6_data", bus.data, 8'h00);
    end
    bus.raw = 8'h00;
    drain("c6");

    tick(5);
    check("final_pending", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
